// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with valid/ready handshakes on both sides.
// A word offered on the last-bit cycle loads directly, so consecutive words stream gaplessly.
module piso_serializer #(
  parameter int N     = 4,
  parameter int CNT_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] parallel_in,
  input  logic         msb_first,
  output logic         serial_out,
  output logic         serial_valid,
  input  logic         serial_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [N-1:0]     shreg;
  logic [CNT_W-1:0] cnt;
  logic             order;

  logic last_bit;
  logic consume;
  logic accept;

  assign last_bit     = (cnt == CNT_W'(N - 1));
  assign busy         = (state == SHIFT);
  assign serial_valid = busy;
  assign consume      = serial_valid && serial_ready;
  assign load_ready   = (state == IDLE) || (last_bit && serial_ready);
  assign accept       = load_valid && load_ready;
  assign serial_out   = busy && (order ? shreg[N-1] : shreg[0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      order <= 1'b1;
      done  <= 1'b0;
    end else begin
      done <= consume && last_bit;
      if (accept) begin
        shreg <= parallel_in;
        order <= msb_first;
        cnt   <= '0;
        state <= SHIFT;
      end else if (consume) begin
        if (last_bit) begin
          state <= IDLE;
        end else begin
          // Shift toward whichever end feeds serial_out, zero-filling behind.
          shreg <= order ? {shreg[N-2:0], 1'b0} : {1'b0, shreg[N-1:1]};
          cnt   <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter N, default 4: parallel word width in bits; legal range N >= 2.
REQ-002 Parameter CNT_W, default $clog2(N): bit-counter width; not overridden by instantiators.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 load_valid  input  1  parallel_in and msb_first hold a word offered for serialisation.
REQ-006 load_ready  output  1  block can accept a word this cycle.
REQ-007 parallel_in  input  N  word to serialise.
REQ-008 msb_first  input  1  bit order for the offered word: 1 = MSB first, 0 = LSB first.
REQ-009 serial_out  output  1  current serial bit.
REQ-010 serial_valid  output  1  serial_out holds a valid bit.
REQ-011 serial_ready  input  1  downstream consumes serial_out this cycle.
REQ-012 busy  output  1  a word is in flight (state SHIFT).
REQ-013 done  output  1  one-cycle pulse: last bit of a word was consumed.

Function
REQ-014 Two states, IDLE and SHIFT; registers: shift register (N bits), bit counter (CNT_W bits), latched order flag, done flag.
REQ-015 Load accept = load_valid && load_ready; bit consume = serial_valid && serial_ready.
REQ-016 load_ready is combinational: 1 in IDLE; 1 in SHIFT only when bit counter = N-1 and serial_ready = 1; otherwise 0.
REQ-017 On load accept: shift register <= parallel_in, order flag <= msb_first, bit counter <= 0, state <= SHIFT.
REQ-018 serial_out = shift register bit N-1 when order flag = 1, bit 0 when order flag = 0; serial_out = 0 in IDLE.
REQ-019 serial_valid = busy = (state == SHIFT).
REQ-020 First bit of an accepted word appears on serial_out the cycle after the accept edge (latency 1).
REQ-021 On consume with counter < N-1: shift register moves one place toward the output end (left for MSB-first, right for LSB-first), zero-filled; counter increments.
REQ-022 Without consume in SHIFT, shift register, counter and serial_out hold (backpressure, unlimited duration).
REQ-023 On consume with counter = N-1 and no load accept: state <= IDLE.
REQ-024 On consume with counter = N-1 and simultaneous load accept: the new word loads per REQ-017, state stays SHIFT; no idle cycle between words.
REQ-025 done is registered: 1 in the cycle after any consume with counter = N-1, else 0; asserts for back-to-back words as well.
REQ-026 load_valid while load_ready = 0 is ignored; parallel_in and msb_first changes then have no effect on the word in flight.
REQ-027 Exactly N consumes occur per accepted word; counter never exceeds N-1.

Reset
REQ-028 reset = 0 forces, asynchronously and at any time including mid-word: state IDLE, shift register 0, counter 0, order flag 1, done 0.
REQ-029 During and after reset until the next accept: serial_out = 0, serial_valid = 0, busy = 0, done = 0, load_ready = 1.
REQ-030 The in-flight word is discarded on reset; no done pulse is generated for it.
REQ-031 Release of reset is synchronous-safe: first load accept can occur on the first rising edge after reset = 1.

Verification (N = 4)
REQ-032 Load 4'b1011, msb_first = 1, serial_ready = 1 constantly -> serial_out 1,0,1,1 on four consecutive cycles, done pulse the following cycle, busy = 0 after.
REQ-033 Load 4'b1011, msb_first = 0 -> serial_out 1,1,0,1; done single pulse after bit 4.
REQ-034 Load 4'b1011 MSB-first, serial_ready = 0 for 3 cycles after bit 2 -> serial_out held at 0, counter held, sequence resumes 1,1; total 4 consumes.
REQ-035 load_valid held high with 4'b1011 then 4'b0110, MSB-first, serial_ready = 1 -> gapless 1,0,1,1,0,1,1,0; load_ready high only in IDLE and on the last-bit cycle; two done pulses 4 cycles apart.
REQ-036 load_valid with 4'b0000 asserted during bit 2 of a word -> ignored, load_ready = 0, current word completes unchanged.
REQ-037 reset = 0 asserted between clock edges during bit 3 -> outputs go to REQ-029 values immediately, no done pulse; after release a new load of 4'b1011 serialises correctly.
